bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DW, default 128, meaning data word width in bits.
REQ-002 SHALL have parameter WL, default 8, meaning BRAM depth in words.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 SHALL have port base, input, 3, first word index of the burst.
REQ-007 SHALL have port len, input, 4, number of words, legal range 1..WL.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse after the last beat is accepted.
REQ-010 SHALL have port err, output, 1, one-cycle pulse when a request is rejected.
REQ-011 SHALL have port bram_en, output, 1, BRAM enable.
REQ-012 SHALL have port bram_we, output, 4, BRAM byte write enables; constant 4'b0000.
REQ-013 SHALL have port bram_a, output, 13, BRAM byte address equal to word index times 4.
REQ-014 SHALL have port bram_do, input, DW, BRAM read data, valid one cycle after bram_a and only while bram_en is high.
REQ-015 SHALL have ports m_tdata (output, DW), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), the stream output.

Function
REQ-016 SHALL implement states IDLE, RUN (addresses still to issue) and DRAIN (all addresses issued, data outstanding).
REQ-017 SHALL, in IDLE, accept start with a legal request and enter RUN next cycle; it latches base and len.
REQ-018 SHALL, in IDLE, reject start with len=0 or len>WL: err pulses the next cycle and the state stays IDLE.
REQ-019 SHALL ignore start while busy is high.
REQ-020 SHALL drive bram_en=1 in RUN and DRAIN and bram_en=0 in IDLE.
REQ-021 SHALL drive bram_a=0 whenever no read is issued in that cycle.
REQ-022 SHALL, for each read issued in cycle t, capture bram_do at the end of cycle t+1 into a 2-entry output FIFO.
REQ-023 SHALL issue a read in cycle t only if FIFO occupancy plus in-flight reads, minus a pop in cycle t, is at most 1, so the FIFO never overflows.
REQ-024 SHALL make a stream beat transfer only when m_tvalid and m_tready are both high.
REQ-025 SHALL keep m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-026 SHALL assert m_tvalid when the FIFO is non-empty; m_tdata is the FIFO head.
REQ-027 SHALL assert m_tlast only on the len-th word of the burst.
REQ-028 SHALL move from RUN to DRAIN in the cycle after the last address is issued.
REQ-029 SHALL leave DRAIN on the handshake of the last beat, pulse done in that same cycle, and be in IDLE the next cycle.
REQ-030 SHALL assert the first m_tvalid 3 cycles after the start cycle (start in cycle 0, address in cycle 1, capture at the end of cycle 2, valid in cycle 3).
REQ-031 SHALL sustain 1 word per cycle while m_tready is held high.
REQ-032 SHALL accept a new start in the first IDLE cycle after done.

Reset
REQ-033 SHALL, while RST=1 at a clock edge, force state IDLE, empty the FIFO, clear the in-flight count, and drive busy, done, err, bram_en, m_tvalid and m_tlast to 0 and bram_a to 0.
REQ-034 SHALL, on reset during RUN or DRAIN, abandon the burst: the in-flight read is discarded, no done pulse is produced, and m_tvalid is low the next cycle.

Configuration
REQ-035 SHALL, with macro BRAM_RD_WRAP_EN defined, compute the word index as (base+i) mod WL, so base=6 with len=4 reads words 6,7,0,1.
REQ-036 SHALL, without BRAM_RD_WRAP_EN, additionally reject any request with base+len>WL, using the err rule of REQ-018.

Verification
REQ-037 SHALL cover: RAM word k = k*0x11..; start with base=0, len=8 and m_tready=1 -> 8 beats on consecutive cycles 3..10, m_tlast on word 7, done in cycle 10.
REQ-038 SHALL cover: base=2, len=3 with m_tready low for cycles 3..6 -> word 2 held stable, no read issued beyond FIFO capacity, words 2,3,4 delivered in order after m_tready rises.
REQ-039 SHALL cover: m_tready toggling 1,0,1,0 across an 8-word burst -> no lost or duplicated words, exactly one m_tlast, one done pulse.
REQ-040 SHALL cover: start with len=0, and start with len=9 -> err pulse for each, busy stays 0, no bram_en.
REQ-041 SHALL cover: base=6, len=4 -> with BRAM_RD_WRAP_EN, words 6,7,0,1; without it, err pulse and no beats.
REQ-042 SHALL cover: RST asserted in cycle 4 of an 8-word burst -> all outputs 0 next cycle; a new start base=1, len=1 then delivers word 1 with m_tlast.

Source files
------------

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - BRAM burst reader feeding a valid/ready stream through a 2-entry FIFO
// Optional feature macro: BRAM_RD_WRAP_EN (word index wraps modulo WL instead of rejecting overruns)
module bram_stream_reader #(
  parameter int DW = 128,
  parameter int WL = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [2:0]    base,
  input  logic [3:0]    len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [12:0]   bram_a,
  input  logic [DW-1:0] bram_do,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [4:0] WL_L    = 5'(WL);
  localparam logic [7:0] IDX_MAX = 8'(WL - 1);

  state_t        state_q, state_d;
  logic [7:0]    idx_q;       // word index of the next read to issue
  logic [3:0]    len_q;
  logic [3:0]    issued_q;    // reads issued so far in this burst
  logic          rd_pend_q;   // a read issued last cycle lands on bram_do now
  logic          rd_last_q;   // that read is the final word of the burst
  logic          err_q;
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          fifo_wr_q;
  logic          fifo_rd_q;
  logic [1:0]    fifo_cnt_q;

  logic          range_ok;
  logic          req_ok;
  logic          accept;
  logic          pop;
  logic          issue;
  logic          issue_last;
  logic [7:0]    idx_next;

`ifdef BRAM_RD_WRAP_EN
  assign range_ok = 1'b1;
  assign idx_next = (idx_q == IDX_MAX) ? 8'd0 : idx_q + 8'd1;
`else
  assign range_ok = ({2'b00, base} + {1'b0, len}) <= WL_L;
  assign idx_next = idx_q + 8'd1;
`endif

  assign req_ok = (len != 4'd0) && ({1'b0, len} <= WL_L) && range_ok;
  assign accept = (state_q == IDLE) && start && req_ok;

  assign m_tvalid = (fifo_cnt_q != 2'd0);
  assign m_tdata  = fifo_data_q[fifo_rd_q];
  assign m_tlast  = m_tvalid && fifo_last_q[fifo_rd_q];
  assign pop      = m_tvalid && m_tready;

  // Issue only when the landing read and this read both still fit after any pop this cycle.
  assign issue = (state_q == RUN) &&
                 (({1'b0, fifo_cnt_q} + {2'b00, rd_pend_q}) <= ({2'b00, pop} + 3'd1));
  assign issue_last = issue && (issued_q == (len_q - 4'd1));

  assign bram_we = 4'b0000;
  assign bram_a  = issue ? {3'b000, idx_q, 2'b00} : 13'd0;
  assign err     = err_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs; the final handshake ends the burst.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    bram_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        bram_en = 1'b1;
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        bram_en = 1'b1;
        if (pop && m_tlast) begin
          state_d = IDLE;
          done    = !RST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: request latch, read address walk, in-flight tracking, reject pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      idx_q     <= 8'd0;
      len_q     <= 4'd0;
      issued_q  <= 4'd0;
    end else begin
      err_q     <= (state_q == IDLE) && start && !req_ok;
      rd_pend_q <= issue;
      rd_last_q <= issue_last;
      if (accept) begin
        idx_q    <= {5'd0, base};
        len_q    <= len;
        issued_q <= 4'd0;
      end else if (issue) begin
        idx_q    <= idx_next;
        issued_q <= issued_q + 4'd1;
      end
    end
  end

  // FIFO control: pointers, occupancy and last-word tags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fifo_wr_q   <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      fifo_last_q <= 2'b00;
    end else begin
      if (rd_pend_q) begin
        fifo_last_q[fifo_wr_q] <= rd_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

  // FIFO data storage; captures the BRAM word one cycle after its address was issued.
  always_ff @(posedge CLK) begin
    if (rd_pend_q) fifo_data_q[fifo_wr_q] <= bram_do;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader
`timescale 1ns/1ps
module tb_bram_stream_reader;
  localparam int DW = 128;
  localparam int WL = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    base = 3'd0;
  logic [3:0]    len = 4'd0;
  logic          busy, done, err, bram_en, m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic [3:0]    bram_we;
  logic [12:0]   bram_a;
  logic [DW-1:0] bram_do = '0;
  logic [DW-1:0] m_tdata;
  logic [DW-1:0] ram [WL];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 CLK = ~CLK;

  bram_stream_reader #(.DW(DW), .WL(WL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .err(err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_do(bram_do),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // Registered-read BRAM model.
  always @(posedge CLK) if (bram_en) bram_do <= ram[bram_a[4:2]];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic rdy);
    @(negedge CLK);
    start    = st;
    m_tready = rdy;
    #1;
  endtask

  task automatic fill_pattern();
    logic [7:0] b;
    for (int k = 0; k < WL; k++) begin
      b = 8'(k * 17);
      ram[k] = {16{b}};
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < WL; k++) ram[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic bit legal(input int b, input int l);
    if (l == 0 || l > WL) return 1'b0;
`ifndef BRAM_RD_WRAP_EN
    if (b + l > WL) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic rdy_of(input int mode, input int cyc);
    case (mode)
      1:       return !(cyc >= 3 && cyc <= 6);
      2:       return (cyc % 2) == 0;
      3:       return $urandom_range(0, 9) < 6;
      default: return 1'b1;
    endcase
  endfunction

  // One request starting in the cycle after the previous burst's last beat (or later).
  task automatic burst(input int b, input int l, input int mode, input string nm);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held_d;
    logic          held_v, held_last, ok;
    int            beats, dones, lasts, issued, first_v, cyc;
    bit            has_zero, finished;
    ok = legal(b, l);
    has_zero = 0;
    if (ok) for (int i = 0; i < l; i++) begin
      exp_q.push_back(ram[(b + i) % WL]);
      if ((b + i) % WL == 0) has_zero = 1;
    end
    base = 3'(b);
    len  = 4'(l);
    step(1'b1, rdy_of(mode, 0));
    chk1({nm, " c0 busy"}, busy, 1'b0);
    chk1({nm, " c0 bram_en"}, bram_en, 1'b0);
    chk1({nm, " c0 tvalid"}, m_tvalid, 1'b0);
    chk1({nm, " c0 done"}, done, 1'b0);
    if (!ok) begin
      for (int c = 1; c <= 4; c++) begin
        step(1'b0, 1'b1);
        chk1({nm, " rej err"}, err, c == 1);
        chk1({nm, " rej busy"}, busy, 1'b0);
        chk1({nm, " rej bram_en"}, bram_en, 1'b0);
        chkw({nm, " rej bram_a"}, DW'(bram_a), '0);
        chk1({nm, " rej tvalid"}, m_tvalid, 1'b0);
      end
      return;
    end
    beats = 0; dones = 0; lasts = 0; issued = 0; first_v = -1;
    held_v = 0; held_last = 0; held_d = '0; finished = 0;
    for (cyc = 1; cyc <= 200 && !finished; cyc++) begin
      step(1'b0, rdy_of(mode, cyc));
      chk1({nm, " busy"}, busy, 1'b1);
      chk1({nm, " bram_en"}, bram_en, 1'b1);
      chk1({nm, " err"}, err, 1'b0);
      chkw({nm, " bram_we"}, DW'(bram_we), '0);
      if (held_v) begin
        chk1({nm, " hold valid"}, m_tvalid, 1'b1);
        chkw({nm, " hold data"}, m_tdata, held_d);
        chk1({nm, " hold last"}, m_tlast, held_last);
      end
      held_v = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_last = m_tlast;
      if (m_tvalid && first_v < 0) begin
        first_v = cyc;
        chki({nm, " first valid cycle"}, cyc, 3);
      end
      if (bram_a != 13'd0) begin
        if (!has_zero && issued < l) chki({nm, " read index"}, int'(bram_a[12:2]), (b + issued) % WL);
        issued++;
      end
      if (m_tvalid && m_tready) begin
        chkw({nm, " beat data"}, m_tdata, exp_q[beats]);
        chk1({nm, " beat last"}, m_tlast, beats == l - 1);
        chk1({nm, " done at last"}, done, beats == l - 1);
        if (mode == 0) chki({nm, " beat cycle"}, cyc, 3 + beats);
        if (m_tlast) lasts++;
        beats++;
      end else begin
        chk1({nm, " done idle"}, done, 1'b0);
      end
      if (done) dones++;
      if (!has_zero) chk1({nm, " outstanding<=2"}, (issued - beats) <= 2, 1'b1);
      if (mode == 1 && cyc == 6 && l >= 2 && !has_zero) chki({nm, " reads during stall"}, issued, 2);
      if (beats == l) finished = 1;
    end
    chk1({nm, " completed in budget"}, finished, 1'b1);
    chki({nm, " beats"}, beats, l);
    chki({nm, " tlast count"}, lasts, 1);
    chki({nm, " done count"}, dones, 1);
  endtask

  initial begin
    int b, l;
    fill_pattern();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst err", err, 1'b0);
    chk1("rst bram_en", bram_en, 1'b0);
    chk1("rst tvalid", m_tvalid, 1'b0);
    chk1("rst tlast", m_tlast, 1'b0);
    chkw("rst bram_a", DW'(bram_a), '0);
    RST = 1'b0;
    step(1'b0, 1'b0);

    burst(0, 8, 0, "full");
    burst(2, 3, 1, "stall");
    burst(0, 8, 2, "toggle");
    burst(0, 0, 0, "len0");
    burst(0, 9, 0, "len9");
    burst(6, 4, 0, "wrap");
    burst(7, 1, 0, "edge7");
    burst(0, 1, 2, "edge0");

    // Reset in cycle 4 of an 8-word burst.
    fill_pattern();
    base = 3'd0;
    len  = 4'd8;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 3; c++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    RST = 1'b1;
    step(1'b0, 1'b1);
    RST = 1'b0;
    chk1("mid rst busy", busy, 1'b0);
    chk1("mid rst done", done, 1'b0);
    chk1("mid rst err", err, 1'b0);
    chk1("mid rst bram_en", bram_en, 1'b0);
    chk1("mid rst tvalid", m_tvalid, 1'b0);
    chk1("mid rst tlast", m_tlast, 1'b0);
    chkw("mid rst bram_a", DW'(bram_a), '0);
    step(1'b0, 1'b0);
    chk1("post rst done", done, 1'b0);
    chk1("post rst tvalid", m_tvalid, 1'b0);
    burst(1, 1, 0, "after rst");

    for (int n = 0; n < 24; n++) begin
      fill_random();
      b = $urandom_range(0, 7);
      l = $urandom_range(0, 9);
      burst(b, l, $urandom_range(0, 3), "rand");
    end

    step(1'b0, 1'b0);
    chk1("final busy", busy, 1'b0);
    chk1("final tvalid", m_tvalid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
